muxnx1_rr: RTL and testbench
============================

# muxnx1_rr

Parametrised N-to-1 multiplexer with a registered output, valid/ready handshaking on every channel, and two selection modes: manual (external select) or round-robin. It generalises the plain combinational 4:1 mux into a flow-controlled channel concentrator. It sits between several producer streams and a single consumer. Throughput is one word per cycle; latency is one cycle.

## Interface
Parameters:
- N, default 4: number of input channels; legal range N ≥ 2, any value (power of two not required).
- W, default 1: data width per channel.
- SW, derived localparam = max(1, $clog2(N)): width of select and channel-index fields.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = manual select via s; 1 = round-robin.
- s  input  SW  manual channel select; used only when mode=0.
- in  input  N*W  channel data; channel k occupies in[k*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational, at most one bit set.
- f  output  W  registered output data.
- f_ch  output  SW  index of the channel that produced f.
- f_valid  output  1  f/f_ch hold a word.
- f_ready  input  1  consumer accepts f this cycle.

## Operation
- Output register free signal: load = !f_valid || f_ready.
- Manual mode (mode=0):
  - Candidate channel is s.
  - A grant occurs when load=1, s < N, and in_valid[s]=1.
  - s ≥ N (possible when N is not a power of two) produces no grant and all in_ready bits stay 0.
- Round-robin mode (mode=1):
  - Candidate is the first channel k with in_valid[k]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - A grant occurs when load=1 and any in_valid bit is set.
- Pointer ptr (SW bits, internal):
  - Updated only on a round-robin grant: ptr ← (k+1) mod N, with wrap from N-1 to 0.
  - Manual-mode grants leave ptr unchanged.
  - Changing mode does not clear ptr.
- Channel handshake: in_ready[k] = 1 only for the granted channel k. The transfer occurs on in_valid[k] && in_ready[k].
- Register update on clk:
  - On a grant: f ← in[k*W +: W], f_ch ← k, f_valid ← 1.
  - With no grant and f_ready=1: f_valid ← 0. f and f_ch keep their last values.
  - With f_valid=1 and f_ready=0: f, f_ch and f_valid hold; in_ready is all 0.
- Simultaneous drain and refill: if f_valid=1, f_ready=1 and a grant occurs in the same cycle, the new word replaces the old one and f_valid stays 1. There is no bubble.
- mode and s are sampled in the same cycle as arbitration. There is no registered select.
- Reset (asynchronous, any time including mid-transfer):
  - f=0, f_ch=0, f_valid=0, ptr=0.
  - in_ready is forced to all 0 while rst=1.
  - A word held in the output register at reset is discarded.

## Timing
- Latency is one cycle: a word accepted at edge t appears on f with f_valid=1 immediately after edge t.
- in_ready depends combinationally on in_valid, mode, s, f_valid and f_ready. There is no combinational path from in to f.
- Sustained throughput is one word per cycle while f_ready=1.
- Round-robin fairness: with all N channels continuously valid and f_ready=1, each channel is granted exactly once every N cycles.
- rst deassertion is used synchronously to clk by the surrounding system. The first grant is possible on the first edge after rst falls.

## Test plan
- Manual basic (N=4, W=1, mode=0, f_ready=1, all in_valid=1):
  - Drive s=0, in=4'b0001; then s=1, in=4'b1101; then s=2, in=4'b0100; then s=3, in=4'b0111.
  - Required: one cycle later each time, f = 1, 0, 1, 0 with f_ch = 0, 1, 2, 3 and f_valid=1.
- Backpressure (N=4, W=8, mode=0, s=2, in_valid=4'b0100, channel 2 data 8'hA5):
  - Hold f_ready=0 for 3 cycles after the first accept.
  - Required: f=8'hA5 and f_valid=1 stable for all 3 cycles, in_ready=0 throughout. Asserting f_ready accepts the next word in the same cycle.
- Round-robin fairness (N=4, mode=1, in_valid=4'b1111, f_ready=1):
  - Required: f_ch sequence 0, 1, 2, 3, 0, 1; in_ready one-hot and rotating.
- Round-robin skip and wrap (N=5, mode=1, in_valid=5'b10010, f_ready=1):
  - Required: f_ch sequence 1, 4, 1, 4. Then set in_valid=5'b00001: next f_ch=0.
- Out-of-range select (N=3, mode=0, s=3, in_valid=3'b111):
  - Required: in_ready=0 and f_valid falls to 0 after one cycle with f_ready=1.
- Mid-operation reset (N=4, mode=1, streaming with ptr=2, f_valid=1):
  - Assert rst between edges.
  - Required: f=0, f_ch=0, f_valid=0, in_ready=0 immediately. After release, the first grant goes to channel 0 with all channels valid.

Source files
------------

// File: rtl/muxnx1_rr.sv
// N-to-1 flow-controlled channel concentrator with a registered output.
// Selection is either an external channel index (mode=0) or round-robin (mode=1).
module muxnx1_rr #(
  parameter int N = 4,
  parameter int W = 1,
  localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SW-1:0]    s,
  input  logic [N*W-1:0]   in,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     f,
  output logic [SW-1:0]    f_ch,
  output logic             f_valid,
  input  logic             f_ready
);

  localparam logic [31:0] NU = 32'(N);

  logic [W-1:0]  f_q, f_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          fv_q, fv_d;

  logic          load;
  logic          grant;
  logic          cand_ok;
  logic [SW-1:0] cand;
  logic [W-1:0]  cand_data;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          man_ok;
  logic [31:0]   idx;
  logic [31:0]   s_ext;

  assign load = !fv_q || f_ready;

  // Search from ptr with explicit wrap, since N need not be a power of two.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    idx      = '0;
    for (int j = 0; j < N; j++) begin
      idx = {{(32-SW){1'b0}}, ptr_q} + 32'(j);
      if (idx >= NU) idx = idx - NU;
      if (!rr_found && in_valid[idx[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = idx[SW-1:0];
      end
    end
  end

  always_comb begin
    s_ext  = {{(32-SW){1'b0}}, s};
    man_ok = 1'b0;
    if (s_ext < NU) man_ok = in_valid[s];
  end

  assign cand    = mode ? rr_idx : s;
  assign cand_ok = mode ? rr_found : man_ok;
  assign grant   = load && cand_ok;

  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    for (int k = 0; k < N; k++) begin
      if (cand == SW'(k)) begin
        in_ready[k] = grant && !rst;
        cand_data   = in[k*W +: W];
      end
    end
  end

  always_comb begin
    f_d   = f_q;
    ch_d  = ch_q;
    fv_d  = fv_q;
    ptr_d = ptr_q;
    if (grant) begin
      f_d  = cand_data;
      ch_d = cand;
      fv_d = 1'b1;
      if (mode) ptr_d = ({{(32-SW){1'b0}}, cand} == NU - 32'd1) ? '0 : cand + 1'b1;
    end else if (f_ready) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q   <= '0;
      ch_q  <= '0;
      fv_q  <= 1'b0;
      ptr_q <= '0;
    end else begin
      f_q   <= f_d;
      ch_q  <= ch_d;
      fv_q  <= fv_d;
      ptr_q <= ptr_d;
    end
  end

  assign f       = f_q;
  assign f_ch    = ch_q;
  assign f_valid = fv_q;

endmodule

// File: tb/tb_muxnx1_rr.sv
// Self-checking bench for muxnx1_rr: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model.
module tb_muxnx1_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // DUT A: N=4, W=8
  logic        a_mode, a_fr, a_fv;
  logic [1:0]  a_s, a_ch;
  logic [31:0] a_in;
  logic [3:0]  a_iv, a_ir;
  logic [7:0]  a_f;
  // DUT B: N=5, W=4
  logic        b_mode, b_fr, b_fv;
  logic [2:0]  b_s, b_ch;
  logic [19:0] b_in;
  logic [4:0]  b_iv, b_ir;
  logic [3:0]  b_f;
  // DUT C: N=3, W=2
  logic        c_mode, c_fr, c_fv;
  logic [1:0]  c_s, c_ch;
  logic [5:0]  c_in;
  logic [2:0]  c_iv, c_ir;
  logic [1:0]  c_f;

  muxnx1_rr #(.N(4), .W(8)) u_a (
    .clk(clk), .rst(rst), .mode(a_mode), .s(a_s), .in(a_in), .in_valid(a_iv),
    .in_ready(a_ir), .f(a_f), .f_ch(a_ch), .f_valid(a_fv), .f_ready(a_fr));
  muxnx1_rr #(.N(5), .W(4)) u_b (
    .clk(clk), .rst(rst), .mode(b_mode), .s(b_s), .in(b_in), .in_valid(b_iv),
    .in_ready(b_ir), .f(b_f), .f_ch(b_ch), .f_valid(b_fv), .f_ready(b_fr));
  muxnx1_rr #(.N(3), .W(2)) u_c (
    .clk(clk), .rst(rst), .mode(c_mode), .s(c_s), .in(c_in), .in_valid(c_iv),
    .in_ready(c_ir), .f(c_f), .f_ch(c_ch), .f_valid(c_fv), .f_ready(c_fr));

  // Reference state for A (index 0) and B (index 1)
  int m_ptr[2], m_fv[2], m_f[2], m_ch[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Channel that wins this cycle, or -1 for no grant.
  function automatic int exp_grant(int n, int ptr, bit md, int sv, int unsigned vm, bit fv, bit fr);
    int best = -1;
    int bestd = n;
    if (fv && !fr) return -1;
    if (!md) return (sv < n && ((vm >> sv) & 1) != 0) ? sv : -1;
    for (int k = 0; k < n; k++) begin
      if (((vm >> k) & 1) != 0 && ((k - ptr + n) % n) < bestd) begin
        best  = k;
        bestd = (k - ptr + n) % n;
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] spread4(input logic [3:0] p);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r[8*k] = p[k];
    return r;
  endfunction

  task automatic stepA(input bit md, input int sv, input logic [31:0] din, input logic [3:0] iv, input bit fr);
    int g;
    @(negedge clk);
    a_mode = md; a_s = 2'(sv); a_in = din; a_iv = iv; a_fr = fr;
    #1;
    g = exp_grant(4, m_ptr[0], md, sv, 32'(iv), m_fv[0] != 0, fr);
    chk("A.in_ready", 32'(a_ir), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (g >= 0) begin
      m_f[0] = int'((din >> (8 * g)) & 32'hFF); m_ch[0] = g; m_fv[0] = 1;
      if (md) m_ptr[0] = (g + 1) % 4;
    end else if (fr) m_fv[0] = 0;
    #1;
    chk("A.f", 32'(a_f), m_f[0]);
    chk("A.f_ch", 32'(a_ch), m_ch[0]);
    chk("A.f_valid", 32'(a_fv), m_fv[0]);
  endtask

  task automatic stepB(input bit md, input int sv, input logic [19:0] din, input logic [4:0] iv, input bit fr);
    int g;
    @(negedge clk);
    b_mode = md; b_s = 3'(sv); b_in = din; b_iv = iv; b_fr = fr;
    #1;
    g = exp_grant(5, m_ptr[1], md, sv, 32'(iv), m_fv[1] != 0, fr);
    chk("B.in_ready", 32'(b_ir), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (g >= 0) begin
      m_f[1] = int'((32'(din) >> (4 * g)) & 32'hF); m_ch[1] = g; m_fv[1] = 1;
      if (md) m_ptr[1] = (g + 1) % 5;
    end else if (fr) m_fv[1] = 0;
    #1;
    chk("B.f", 32'(b_f), m_f[1]);
    chk("B.f_ch", 32'(b_ch), m_ch[1]);
    chk("B.f_valid", 32'(b_fv), m_fv[1]);
  endtask

  // Asserts rst between edges, checks the immediate effect, then leaves all channels idle.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst.A.f", 32'(a_f), 0);      chk("rst.A.f_ch", 32'(a_ch), 0);
    chk("rst.A.f_valid", 32'(a_fv), 0); chk("rst.A.in_ready", 32'(a_ir), 0);
    chk("rst.B.f_valid", 32'(b_fv), 0); chk("rst.B.in_ready", 32'(b_ir), 0);
    chk("rst.C.f_valid", 32'(c_fv), 0); chk("rst.C.in_ready", 32'(c_ir), 0);
    for (int i = 0; i < 2; i++) begin m_ptr[i] = 0; m_fv[i] = 0; m_f[i] = 0; m_ch[i] = 0; end
    a_iv = '0; b_iv = '0; c_iv = '0; a_fr = 1'b1; b_fr = 1'b1; c_fr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic driveC(input bit md, input logic [1:0] sv, input logic [5:0] din, input logic [2:0] iv, input bit fr);
    @(negedge clk);
    c_mode = md; c_s = sv; c_in = din; c_iv = iv; c_fr = fr;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_mode = 0; a_s = 0; a_in = 0; a_iv = 0; a_fr = 1;
    b_mode = 0; b_s = 0; b_in = 0; b_iv = 0; b_fr = 1;
    c_mode = 0; c_s = 0; c_in = 0; c_iv = 0; c_fr = 1;
    do_reset();

    // Manual basic: channel k carries bit k of the pattern
    stepA(0, 0, spread4(4'b0001), 4'hF, 1); chk("man.f0", 32'(a_f), 1); chk("man.ch0", 32'(a_ch), 0);
    stepA(0, 1, spread4(4'b1101), 4'hF, 1); chk("man.f1", 32'(a_f), 0); chk("man.ch1", 32'(a_ch), 1);
    stepA(0, 2, spread4(4'b0100), 4'hF, 1); chk("man.f2", 32'(a_f), 1); chk("man.ch2", 32'(a_ch), 2);
    stepA(0, 3, spread4(4'b0111), 4'hF, 1); chk("man.f3", 32'(a_f), 0); chk("man.ch3", 32'(a_ch), 3);
    chk("man.fv", 32'(a_fv), 1);

    // Backpressure
    stepA(0, 2, 32'h00A5_0000, 4'b0100, 1);
    for (int i = 0; i < 3; i++) begin
      stepA(0, 2, 32'h005A_0000, 4'b0100, 0);
      chk("bp.f", 32'(a_f), 32'hA5); chk("bp.fv", 32'(a_fv), 1);
    end
    stepA(0, 2, 32'h005A_0000, 4'b0100, 1);
    chk("bp.next", 32'(a_f), 32'h5A);

    // Round-robin fairness
    do_reset();
    for (int i = 0; i < 6; i++) begin
      stepA(1, 0, 32'h4433_2211, 4'hF, 1);
      chk("rr.ch", 32'(a_ch), i % 4);
    end

    // Skip and wrap on N=5
    for (int i = 0; i < 4; i++) begin
      stepB(1, 0, 20'h54321, 5'b10010, 1);
      chk("skip.ch", 32'(b_ch), (i % 2 == 0) ? 1 : 4);
    end
    stepB(1, 0, 20'h54321, 5'b00001, 1);
    chk("skip.ch0", 32'(b_ch), 0);

    // Out-of-range select on N=3
    driveC(0, 2'd0, 6'b10_01_11, 3'b111, 1);
    chk("oor.ir0", 32'(c_ir), 1);
    @(posedge clk); #1;
    chk("oor.fv1", 32'(c_fv), 1); chk("oor.f", 32'(c_f), 3);
    driveC(0, 2'd3, 6'b10_01_11, 3'b111, 1);
    chk("oor.ir", 32'(c_ir), 0);
    @(posedge clk); #1;
    chk("oor.fv0", 32'(c_fv), 0);

    // Mid-operation reset with ptr=2 and a word held
    do_reset();
    stepA(1, 0, 32'h4433_2211, 4'hF, 1);
    stepA(1, 0, 32'h4433_2211, 4'hF, 1);
    chk("mid.pre", 32'(a_f), 32'h22);
    do_reset();
    stepA(1, 0, 32'h4433_2211, 4'hF, 1);
    chk("mid.first", 32'(a_ch), 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      stepA(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 400; i++) begin
      stepB(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 20'($urandom),
            5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
